obc_oam_engine: RTL and testbench
=================================

Name: obc_oam_engine

Overview:
- Parametrised successor of the OBC1 OAM coprocessor on the SNES cartridge bus.
- Holds NUM_BANKS banks of sprite attribute tables, each with a low table (4 bytes per object) and a high table (2 bits per object).
- Supports register-indexed object access with optional auto-increment, plus direct byte windows.
- Adds a hardware bank-copy and bank-clear engine that runs one byte per cycle while reporting busy.

Parameters:
- NUM_OBJ, 128: objects per bank; must be a power of 2 and at least 4.
- NUM_BANKS, 2: number of banks; must be a power of 2.
- REG_BASE, 13'h1ff0: base address of the eight registers; 8-aligned.
- LOW_BASE, 13'h1800: direct low-table window; size NUM_OBJ*4 bytes.
- HIGH_BASE, 13'h1a00: direct high-table window; size NUM_OBJ/4 bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  chip select from the address decoder.
- addr_in  in  13  SNES address, low bits.
- data_in  in  8  SNES write data.
- reg_oe  in  1  read strobe, active low.
- reg_we  in  1  write strobe, active low.
- data_out  out  8  read data, registered.
- busy  out  1  copy or clear engine running.

Behaviour:
- Write event: cycle where enable & ~reg_we is true and was false on the previous cycle. Address and data are sampled in that cycle, so a held strobe gives exactly one write.
- Register 0-3: X, Y, tile and attr bytes of object OBJ in bank BANK. Write goes to RAM; read comes from RAM.
- Register 4:
  - Write stores data_in[1:0] into the 2-bit high slot of OBJ.
  - Read returns {6'b0, slot}.
- Register 5: bit0..log2(NUM_BANKS)-1 is BANK; bit7 is AUTOINC. Other bits read 0.
- Register 6: OBJ [log2(NUM_OBJ)-1:0]. Upper bits read 0.
- Register 7:
  - Write bit0=1 starts COPY of BANK to bank BANK^1.
  - Write bit1=1 starts CLEAR of BANK.
  - Both bits set: CLEAR wins.
  - Read returns {busy, 5'b0, last_op[1:0]}.
- Auto-increment: when AUTOINC=1, a write event to reg 4 increments OBJ modulo NUM_OBJ (wraps 127 -> 0).
- Direct low window: LOW_BASE + n maps to byte n of BANK's low table.
- Direct high window: HIGH_BASE + m maps to the packed byte for objects 4m..4m+3, with slot k at bits [2k+1:2k].
- High RAM organisation: four 2-bit lanes; register-4 writes enable only lane OBJ[1:0], so no read-modify-write is needed.
- Read latency: data_out updates on the clk edge after address and enable are valid (one cycle); SNES sampling allows this.
- Unmapped address, or enable low: data_out <= 8'h77.
- States: IDLE, COPY, CLEAR.
  - IDLE -> COPY or CLEAR on the reg-7 write event.
  - Index idx runs 0..NUM_OBJ*4 + NUM_OBJ/4 - 1: low bytes first, then high bytes.
  - CLEAR writes 1 byte/cycle: Y byte (idx%4==1) = 8'hE0, others 8'h00, high bytes 8'h00. Duration NUM_OBJ*4 + NUM_OBJ/4 cycles (544 at default).
  - COPY reads source at idx and writes destination one cycle later. Duration 545 cycles at default.
  - Return to IDLE after the last write.
- busy is high from the edge following the start event through the last engine write.
- While busy:
  - All SNES write events are dropped, including registers 4-7.
  - RAM reads return 8'hFF; register reads return normally.
- Reset (async): registers 0 and engine returns to IDLE; data_out 8'h00; busy 0; last_op 0. RAM is not cleared; reset mid-operation leaves it partially processed.

Decomposition:
- Package obc_pkg: register offsets (REG_OBJ0..REG_CTRL), state enum, CLR_Y=8'hE0, OPEN_BUS=8'h77, BUSY_READ=8'hFF, helper localparams for widths and idx end.
- Sub-module obc_oam_ram: dual-port inferred block RAM for both tables, low byte-wide plus four 2-bit high lanes with per-lane write enables. Port A is SNES access; port B is the engine.
- The engine lives in the top level; roughly 250 lines total.

Test Plan:
- Reset, then read REG_BASE+7 -> 8'h00; read 13'h0000 with enable=1 -> 8'h77.
- AUTOINC: write reg5=8'h80, reg6=8'h7F, reg0-3=11,22,33,44, reg4=3 -> reg6 reads 0; LOW_BASE+0x1FC..1FF = 11,22,33,44; HIGH_BASE+0x1F = 8'hC0.
- Hold reg_we low for 5 cycles on reg4 with AUTOINC -> OBJ increments once.
- CLEAR bank 0 via reg7=2 -> busy for 544 cycles; LOW_BASE+1 reads E0, +0 reads 00; direct read during busy reads FF; a write during busy is lost.
- Fill bank 0 with a pattern, then COPY via reg7=1 -> busy for 545 cycles; set BANK=1 and all 544 bytes match.
- Assert rst_n low mid-COPY -> busy 0 immediately; registers read 0; a new CLEAR runs normally.

Source files
------------

// File: rtl/obc_pkg.sv
// Shared constants, state encoding and sizing helpers for the OBC OAM engine.
package obc_pkg;

    localparam logic [2:0] REG_OBJ0 = 3'd0;
    localparam logic [2:0] REG_OBJ1 = 3'd1;
    localparam logic [2:0] REG_OBJ2 = 3'd2;
    localparam logic [2:0] REG_OBJ3 = 3'd3;
    localparam logic [2:0] REG_HIGH = 3'd4;
    localparam logic [2:0] REG_BANK = 3'd5;
    localparam logic [2:0] REG_IDX  = 3'd6;
    localparam logic [2:0] REG_CTRL = 3'd7;

    localparam logic [7:0] CLR_Y     = 8'hE0;
    localparam logic [7:0] OPEN_BUS  = 8'h77;
    localparam logic [7:0] BUSY_READ = 8'hFF;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_COPY  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_CLEAR} state_t;

    // Engine steps per bank: every low byte followed by every packed high byte.
    function automatic int idx_count(input int num_obj);
        return num_obj * 4 + num_obj / 4;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obc_oam_ram.sv
// Sprite attribute storage: byte-wide low table plus four 2-bit high lanes.
// Port A (SNES) reads combinationally; port B (engine) reads registered, writes by separate address.
module obc_oam_ram #(
    parameter int LMAW = 10,
    parameter int HMAW = 6
) (
    input  logic            clk,
    input  logic [LMAW-1:0] a_low_addr_i,
    input  logic            a_low_we_i,
    input  logic [7:0]      a_low_wdat_i,
    output logic [7:0]      a_low_rdat_o,
    input  logic [HMAW-1:0] a_high_addr_i,
    input  logic [3:0]      a_high_we_i,
    input  logic [7:0]      a_high_wdat_i,
    output logic [7:0]      a_high_rdat_o,
    input  logic [LMAW-1:0] b_low_raddr_i,
    input  logic [LMAW-1:0] b_low_waddr_i,
    input  logic            b_low_we_i,
    input  logic [HMAW-1:0] b_high_raddr_i,
    input  logic [HMAW-1:0] b_high_waddr_i,
    input  logic            b_high_we_i,
    input  logic [7:0]      b_wdat_i,
    output logic [7:0]      b_low_rdat_o,
    output logic [7:0]      b_high_rdat_o
);

    logic [7:0] low_mem  [1 << LMAW];
    logic [7:0] high_mem [1 << HMAW];

    assign a_low_rdat_o  = low_mem[a_low_addr_i];
    assign a_high_rdat_o = high_mem[a_high_addr_i];

    always_ff @(posedge clk) begin
        if (a_low_we_i) low_mem[a_low_addr_i] <= a_low_wdat_i;
        for (int k = 0; k < 4; k++) begin
            if (a_high_we_i[k]) high_mem[a_high_addr_i][2*k +: 2] <= a_high_wdat_i[2*k +: 2];
        end
        if (b_low_we_i)  low_mem[b_low_waddr_i]   <= b_wdat_i;
        if (b_high_we_i) high_mem[b_high_waddr_i] <= b_wdat_i;
        b_low_rdat_o  <= low_mem[b_low_raddr_i];
        b_high_rdat_o <= high_mem[b_high_raddr_i];
    end

endmodule

// File: rtl/obc_oam_engine.sv
// OBC1-style OAM coprocessor with banked tables and a one-byte-per-cycle copy/clear engine.
// Reads land on data_out one clock after address; SNES writes are dropped while busy.
module obc_oam_engine
    import obc_pkg::*;
#(
    parameter int          NUM_OBJ   = 128,
    parameter int          NUM_BANKS = 2,
    parameter logic [12:0] REG_BASE  = 13'h1ff0,
    parameter logic [12:0] LOW_BASE  = 13'h1800,
    parameter logic [12:0] HIGH_BASE = 13'h1a00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [12:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        reg_oe,
    input  logic        reg_we,
    output logic [7:0]  data_out,
    output logic        busy
);

    localparam int OW   = $clog2(NUM_OBJ);
    localparam int BW   = clog2_min1(NUM_BANKS);
    localparam int LAW  = OW + 2;
    localparam int HAW  = OW - 2;
    localparam int ICNT = idx_count(NUM_OBJ);
    localparam int IW   = $clog2(ICNT + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(ICNT - 1);
    localparam logic [IW-1:0] IDX_DRAIN = IW'(ICNT);
    localparam logic [IW-1:0] LOW_END   = IW'(NUM_OBJ * 4);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] bank_q;
    logic [OW-1:0] obj_q;
    logic          autoinc_q, we_prev_q;
    logic [1:0]    last_op_q;
    logic [7:0]    data_out_q;

    logic [12:0]   low_off, high_off;
    logic          reg_hit, low_hit, high_hit, acc_ok, start_cmd;
    logic [2:0]    reg_sel;
    logic [7:0]    rd_dat, a_low_rdat, a_high_rdat, b_low_rdat, b_high_rdat;
    logic [1:0]    slot;
    logic          a_low_we;
    logic [3:0]    a_high_we;
    logic [IW-1:0] w_idx, hr_off, hw_off;
    logic          w_low, eng_we;
    logic [7:0]    eng_wdat;
    logic [BW-1:0] dst_bank;

    assign busy     = (state_q != ST_IDLE);
    assign data_out = data_out_q;

    assign low_off  = addr_in - LOW_BASE;
    assign high_off = addr_in - HIGH_BASE;
    assign reg_hit  = (addr_in[12:3] == REG_BASE[12:3]);
    assign low_hit  = (low_off < 13'(NUM_OBJ * 4));
    assign high_hit = (high_off < 13'(NUM_OBJ / 4));
    assign reg_sel  = addr_in[2:0];

    // A held strobe counts once: only the first cycle of enable & ~reg_we is an event.
    assign acc_ok    = enable & ~reg_we & ~we_prev_q & ~busy;
    assign start_cmd = acc_ok & reg_hit & (reg_sel == REG_CTRL) & (data_in[1] | data_in[0]);

    assign a_low_we  = acc_ok & (reg_hit ? ~reg_sel[2] : low_hit);
    assign a_high_we = !acc_ok ? 4'b0000 :
                       reg_hit ? ((reg_sel == REG_HIGH) ? (4'b0001 << obj_q[1:0]) : 4'b0000) :
                       (!low_hit && high_hit) ? 4'b1111 : 4'b0000;
    assign slot      = a_high_rdat[{obj_q[1:0], 1'b0} +: 2];

    assign w_idx    = (state_q == ST_COPY) ? idx_q - IW'(1) : idx_q;
    assign w_low    = (w_idx < LOW_END);
    assign hr_off   = idx_q - LOW_END;
    assign hw_off   = w_idx - LOW_END;
    assign dst_bank = (state_q == ST_COPY) ? bank_q ^ BW'(1) : bank_q;

    logic unused_bits;
    assign unused_bits = ^{hr_off[IW-1:HAW], hw_off[IW-1:HAW]};

    obc_oam_ram #(.LMAW(BW + LAW), .HMAW(BW + HAW)) u_ram (
        .clk            (clk),
        .a_low_addr_i   (reg_hit ? {bank_q, obj_q, reg_sel[1:0]} : {bank_q, low_off[LAW-1:0]}),
        .a_low_we_i     (a_low_we),
        .a_low_wdat_i   (data_in),
        .a_low_rdat_o   (a_low_rdat),
        .a_high_addr_i  (reg_hit ? {bank_q, obj_q[OW-1:2]} : {bank_q, high_off[HAW-1:0]}),
        .a_high_we_i    (a_high_we),
        .a_high_wdat_i  (reg_hit ? {4{data_in[1:0]}} : data_in),
        .a_high_rdat_o  (a_high_rdat),
        .b_low_raddr_i  ({bank_q, idx_q[LAW-1:0]}),
        .b_low_waddr_i  ({dst_bank, w_idx[LAW-1:0]}),
        .b_low_we_i     (eng_we & w_low),
        .b_high_raddr_i ({bank_q, hr_off[HAW-1:0]}),
        .b_high_waddr_i ({dst_bank, hw_off[HAW-1:0]}),
        .b_high_we_i    (eng_we & ~w_low),
        .b_wdat_i       (eng_wdat),
        .b_low_rdat_o   (b_low_rdat),
        .b_high_rdat_o  (b_high_rdat)
    );

    always_comb begin
        rd_dat = OPEN_BUS;
        if (reg_hit) begin
            case (reg_sel)
                REG_OBJ0, REG_OBJ1, REG_OBJ2, REG_OBJ3: rd_dat = busy ? BUSY_READ : a_low_rdat;
                REG_HIGH: rd_dat = busy ? BUSY_READ : {6'b0, slot};
                REG_BANK: rd_dat = {autoinc_q, 7'(bank_q)};
                REG_IDX:  rd_dat = 8'(obj_q);
                default:  rd_dat = {busy, 5'b0, last_op_q};
            endcase
        end else if (low_hit) begin
            rd_dat = busy ? BUSY_READ : a_low_rdat;
        end else if (high_hit) begin
            rd_dat = busy ? BUSY_READ : a_high_rdat;
        end
    end

    // COPY reads idx and writes idx-1, so it needs one drain step past the last read.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        eng_we   = 1'b0;
        eng_wdat = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_d = data_in[1] ? ST_CLEAR : ST_COPY;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                eng_we   = 1'b1;
                eng_wdat = (w_low && idx_q[1:0] == 2'd1) ? CLR_Y : 8'h00;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_COPY: begin
                eng_we   = (idx_q != '0);
                eng_wdat = w_low ? b_low_rdat : b_high_rdat;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IDX_DRAIN) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bank_q     <= '0;
            obj_q      <= '0;
            autoinc_q  <= 1'b0;
            we_prev_q  <= 1'b0;
            last_op_q  <= OP_NONE;
            data_out_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            we_prev_q <= enable & ~reg_we;
            if (!enable)     data_out_q <= OPEN_BUS;
            else if (!reg_oe) data_out_q <= rd_dat;
            if (acc_ok && reg_hit) begin
                case (reg_sel)
                    REG_HIGH: if (autoinc_q) obj_q <= obj_q + OW'(1);
                    REG_BANK: begin
                        bank_q    <= data_in[BW-1:0];
                        autoinc_q <= data_in[7];
                    end
                    REG_IDX:  obj_q <= data_in[OW-1:0];
                    REG_CTRL: begin
                        if (data_in[1])      last_op_q <= OP_CLEAR;
                        else if (data_in[0]) last_op_q <= OP_COPY;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obc_oam_engine.sv
// Scenario bench for obc_oam_engine: register access, auto-increment, clear, copy and async reset.
module tb_obc_oam_engine;

    localparam logic [12:0] REG_BASE  = 13'h1ff0;
    localparam logic [12:0] LOW_BASE  = 13'h1800;
    localparam logic [12:0] HIGH_BASE = 13'h1a00;

    logic        clk, rst_n, enable, reg_oe, reg_we, busy;
    logic [12:0] addr_in;
    logic [7:0]  data_in, data_out;

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         busy_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] copy_q[$];

    obc_oam_engine #(
        .NUM_OBJ(128), .NUM_BANKS(2), .REG_BASE(REG_BASE), .LOW_BASE(LOW_BASE), .HIGH_BASE(HIGH_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .addr_in(addr_in), .data_in(data_in),
        .reg_oe(reg_oe), .reg_we(reg_we), .data_out(data_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy) busy_cyc++;

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; addr_in = a; data_in = d; reg_we = 1'b0;
        @(negedge clk);
        reg_we = 1'b1; enable = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; reg_oe = 1'b0; addr_in = a;
        @(posedge clk);
        #1 d = data_out;
        reg_oe = 1'b1; enable = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 3000 && busy; g++) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v, e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h00);
        v = data_out; e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL reset_data_out: got %h expected %h", v, e); else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back(8'h00); rd(REG_BASE + 13'd7, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL reset_ctrl: got %h expected %h", v, e); else pass_cnt++;
        exp_q.push_back(8'h77); rd(13'h0000, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL unmapped: got %h expected %h", v, e); else pass_cnt++;
        exp_q.push_back(8'h77);
        @(negedge clk) begin enable = 1'b0; reg_oe = 1'b0; addr_in = REG_BASE + 13'd7; end
        @(posedge clk) #1 v = data_out;
        reg_oe = 1'b1; e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL enable_low: got %h expected %h", v, e); else pass_cnt++;
    endtask

    task automatic test_clear();
        logic [7:0]  v, e;
        int          b0, n;
        logic [12:0] a [8];
        logic [7:0]  x [8];
        a = '{LOW_BASE, LOW_BASE + 13'd1, LOW_BASE + 13'h1fd, LOW_BASE + 13'h1fe,
              HIGH_BASE, HIGH_BASE + 13'h1f, REG_BASE + 13'd6, REG_BASE + 13'd7};
        x = '{8'h00, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        b0 = busy_cyc;
        wr(REG_BASE + 13'd7, 8'h02);
        exp_q.push_back(8'hFF); rd(LOW_BASE + 13'd1, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL clear_busy_read: got %h expected %h", v, e); else pass_cnt++;
        exp_q.push_back(8'h82); rd(REG_BASE + 13'd7, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL clear_ctrl_busy: got %h expected %h", v, e); else pass_cnt++;
        wr(LOW_BASE, 8'h55);
        wr(REG_BASE + 13'd6, 8'h33);
        wait_idle();
        n = busy_cyc - b0; chk_cnt++;
        if (n != 544) $display("FAIL clear_cycles: got %0d expected 544", n); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(x[i]); rd(a[i], v); e = exp_q.pop_front(); chk_cnt++;
            if (v !== e) $display("FAIL clear_rd[%0d]: got %h expected %h", i, v, e); else pass_cnt++;
        end
    endtask

    task automatic test_autoinc();
        logic [7:0]  v, e;
        logic [12:0] a [8];
        logic [7:0]  x [8];
        a = '{REG_BASE + 13'd6, REG_BASE + 13'd5, LOW_BASE + 13'h1fc, LOW_BASE + 13'h1fd,
              LOW_BASE + 13'h1fe, LOW_BASE + 13'h1ff, HIGH_BASE + 13'h1f, REG_BASE + 13'd4};
        x = '{8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC0, 8'h00};
        wr(REG_BASE + 13'd5, 8'h80);
        wr(REG_BASE + 13'd6, 8'h7F);
        wr(REG_BASE + 13'd0, 8'h11);
        wr(REG_BASE + 13'd1, 8'h22);
        wr(REG_BASE + 13'd2, 8'h33);
        wr(REG_BASE + 13'd3, 8'h44);
        wr(REG_BASE + 13'd4, 8'h03);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(x[i]); rd(a[i], v); e = exp_q.pop_front(); chk_cnt++;
            if (v !== e) $display("FAIL autoinc_rd[%0d]: got %h expected %h", i, v, e); else pass_cnt++;
        end
    endtask

    task automatic test_hold_strobe();
        logic [7:0] v, e;
        @(negedge clk);
        enable = 1'b1; addr_in = REG_BASE + 13'd4; data_in = 8'h02; reg_we = 1'b0;
        repeat (5) @(negedge clk);
        reg_we = 1'b1; enable = 1'b0;
        exp_q.push_back(8'h01); rd(REG_BASE + 13'd6, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL hold_obj: got %h expected %h", v, e); else pass_cnt++;
        exp_q.push_back(8'h02); rd(HIGH_BASE, v); e = exp_q.pop_front(); chk_cnt++;
        if (v !== e) $display("FAIL hold_slot: got %h expected %h", v, e); else pass_cnt++;
    endtask

    task automatic test_copy();
        logic [7:0]  v, e, d;
        logic [12:0] a;
        int          b0, n;
        wr(REG_BASE + 13'd5, 8'h00);
        for (int i = 0; i < 544; i++) begin
            a = (i < 512) ? LOW_BASE + 13'(i) : HIGH_BASE + 13'(i - 512);
            d = (i < 512) ? 8'((i * 7 + 3) & 255) : 8'((i * 13 + 5) & 255);
            wr(a, d);
            copy_q.push_back(d);
        end
        b0 = busy_cyc;
        wr(REG_BASE + 13'd7, 8'h01);
        wait_idle();
        n = busy_cyc - b0; chk_cnt++;
        if (n != 545) $display("FAIL copy_cycles: got %0d expected 545", n); else pass_cnt++;
        rd(REG_BASE + 13'd7, v); chk_cnt++;
        if (v !== 8'h01) $display("FAIL copy_last_op: got %h expected 01", v); else pass_cnt++;
        wr(REG_BASE + 13'd5, 8'h01);
        for (int i = 0; i < 544; i++) begin
            a = (i < 512) ? LOW_BASE + 13'(i) : HIGH_BASE + 13'(i - 512);
            rd(a, v); e = copy_q.pop_front(); chk_cnt++;
            if (v !== e) $display("FAIL copy_byte[%0d]: got %h expected %h", i, v, e); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_copy();
        logic [7:0]  v, e;
        int          b0, n;
        logic [12:0] a [5];
        logic [7:0]  x [5];
        a = '{REG_BASE + 13'd5, REG_BASE + 13'd6, REG_BASE + 13'd7, LOW_BASE + 13'd1, LOW_BASE + 13'h1fc};
        x = '{8'h00, 8'h00, 8'h00, 8'hE0, 8'h00};
        wr(REG_BASE + 13'd5, 8'h81);
        wr(REG_BASE + 13'd6, 8'h10);
        wr(REG_BASE + 13'd7, 8'h01);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++;
        if (data_out !== 8'h00) $display("FAIL midrst_data_out: got %h expected 00", data_out); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(x[i]); rd(a[i], v); e = exp_q.pop_front(); chk_cnt++;
            if (v !== e) $display("FAIL midrst_reg[%0d]: got %h expected %h", i, v, e); else pass_cnt++;
        end
        b0 = busy_cyc;
        wr(REG_BASE + 13'd7, 8'h03);
        wait_idle();
        n = busy_cyc - b0; chk_cnt++;
        if (n != 544) $display("FAIL midrst_clear_cycles: got %0d expected 544", n); else pass_cnt++;
        for (int i = 3; i < 5; i++) begin
            exp_q.push_back(x[i]); rd(a[i], v); e = exp_q.pop_front(); chk_cnt++;
            if (v !== e) $display("FAIL midrst_clear[%0d]: got %h expected %h", i, v, e); else pass_cnt++;
        end
        rd(REG_BASE + 13'd7, v); chk_cnt++;
        if (v !== 8'h02) $display("FAIL midrst_last_op: got %h expected 02", v); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; reg_oe = 1'b1; reg_we = 1'b1;
        addr_in = '0; data_in = '0;
        test_reset();
        test_clear();
        test_autoinc();
        test_hold_strobe();
        test_copy();
        test_reset_mid_copy();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
